// File: rtl/time_display.sv
// Six-digit scanned seven-segment driver: binary h/m/s -> BCD via a sequential
// subtract-by-ten engine, multiplexed onto a common-anode display. Optional blink: TIME_DISPLAY_BLINK_EN.

module time_display_seg7 (
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  always_comb begin
    seg = 7'b1111111;
    case (bcd)
      4'd0: seg = 7'b1000000;
      4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;
      4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;
      4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;
      4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
  end
endmodule

module time_display #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 12500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] hour,
  input  logic [5:0] minute,
  input  logic [5:0] second,
  input  logic       stop,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp
);
  localparam int DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int NUM_DIG = 6;

  typedef enum logic [2:0] {IDLE, LOAD, CONV_H, CONV_M, CONV_S, COMMIT} state_t;

  logic [DIV_W-1:0] div;
  logic [2:0]       slot;
  logic             div_tc;
  logic             first;
  logic             frame_start;
  logic             blank;

  state_t state, nxt;
  logic [2:0][5:0]         work;
  logic [2:0][3:0]         tens;
  logic [2:0][3:0]         ones;
  logic [NUM_DIG-1:0][3:0] disp;
  logic [NUM_DIG-1:0][6:0] seg_dig;
  logic [1:0]              fld;
  logic                    ge10;

  // scan divider and slot index
  assign div_tc = (div == DIV_W'(SCAN_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div  <= '0;
      slot <= '0;
    end else if (div_tc) begin
      div  <= '0;
      slot <= (slot == 3'd5) ? 3'd0 : slot + 3'd1;
    end else begin
      div <= div + 1'b1;
    end
  end

  // one forced conversion right after reset release, then one per frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) first <= 1'b1;
    else     first <= 1'b0;
  end

  assign frame_start = first | (div_tc & (slot == 3'd5));

  // conversion FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    fld = 2'd0;
    case (state)
      CONV_M:  fld = 2'd1;
      CONV_S:  fld = 2'd2;
      default: fld = 2'd0;
    endcase
  end

  assign ge10 = (work[fld] >= 6'd10);

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (frame_start) nxt = LOAD;
      LOAD:    nxt = CONV_H;
      CONV_H:  if (!ge10) nxt = CONV_M;
      CONV_M:  if (!ge10) nxt = CONV_S;
      CONV_S:  if (!ge10) nxt = COMMIT;
      COMMIT:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // field 0 = hour, 1 = minute, 2 = second; display digit k = slot k
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work <= '0;
      tens <= '0;
      ones <= '0;
      disp <= '0;
    end else begin
      case (state)
        LOAD: begin
          work <= {second, minute, {1'b0, hour}};
          tens <= '0;
        end
        CONV_H, CONV_M, CONV_S: begin
          if (ge10) begin
            work[fld] <= work[fld] - 6'd10;
            tens[fld] <= tens[fld] + 4'd1;
          end else begin
            ones[fld] <= work[fld][3:0];
          end
        end
        COMMIT: disp <= {ones[2], tens[2], ones[1], tens[1], ones[0], tens[0]};
        default: ;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_DIG; i++) begin : g_dec
    time_display_seg7 u_dec (.bcd(disp[i]), .seg(seg_dig[i]));
  end

`ifdef TIME_DISPLAY_BLINK_EN
  localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  logic [BLK_W-1:0] bcnt;
  logic             phase_on;

  // blink phase only advances in adjust mode; leaving it restarts lit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt     <= '0;
      phase_on <= 1'b1;
    end else if (!stop) begin
      bcnt     <= '0;
      phase_on <= 1'b1;
    end else if (bcnt == BLK_W'(BLINK_DIV - 1)) begin
      bcnt     <= '0;
      phase_on <= ~phase_on;
    end else begin
      bcnt <= bcnt + 1'b1;
    end
  end

  assign blank = stop & ~phase_on;
`else
  logic unused_cfg;
  assign unused_cfg = stop | (BLINK_DIV < 1);
  assign blank      = 1'b0;
`endif

  // registered pins, one cycle behind the slot index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an  <= '1;
      seg <= '1;
      dp  <= 1'b1;
    end else begin
      an  <= blank ? 6'b111111 : ~(6'b100000 >> slot);
      seg <= seg_dig[slot];
      dp  <= ~((slot == 3'd1) | (slot == 3'd3));
    end
  end
endmodule

// File: tb/tb_time_display.sv
// Scoreboard bench for time_display: stimulus pushes expected per-slot pin
// values, a negedge monitor pops one entry at the end of every scanned slot.

module tb_time_display;
  localparam int SD = 32;

  typedef struct packed {
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] hour = 5'd23;
  logic [5:0] minute = 6'd59;
  logic [5:0] second = 6'd58;
  logic       stop = 1'b0;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;

  int   checks = 0;
  int   failures = 0;
  int   frame_cnt = 0;
  bit   per_en = 1'b0;
  exp_t q[$];

  time_display #(.SCAN_DIV(SD), .BLINK_DIV(64)) dut (
    .clk(clk), .rst(rst), .hour(hour), .minute(minute), .second(second),
    .stop(stop), .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push_frame(input int h, input int m, input int s);
    int   d[6];
    exp_t e;
    d = '{h / 10, h % 10, m / 10, m % 10, s / 10, s % 10};
    for (int k = 0; k < 6; k++) begin
      e.an  = ~(6'b100000 >> k);
      e.seg = seg_of(d[k]);
      e.dp  = (k == 1 || k == 3) ? 1'b0 : 1'b1;
      q.push_back(e);
    end
  endtask

  task automatic wait_frame_since(input int f0);
    for (int i = 0; i < 8 * SD; i++) begin
      @(posedge clk);
      if (frame_cnt != f0) return;
    end
    chk("frame_timeout", frame_cnt, f0 + 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 16 * SD; i++) begin
      @(posedge clk);
      if (q.size() == 0) return;
    end
    chk("drain_timeout", q.size(), 0);
    q.delete();
  endtask

  task automatic count_blank(input int n, output int nb);
    nb = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (an == 6'b111111) nb++;
    end
  endtask

  // monitor: each time an changes, the slot just finished is scored
  logic [5:0] p_an = '1;
  logic [6:0] p_seg = '1;
  logic       p_dp = 1'b1;
  int         cyc = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      p_an = '1; p_seg = '1; p_dp = 1'b1; cyc = 0;
    end else begin
      cyc++;
      if (an != p_an) begin
        if (p_an != 6'b111111 && an != 6'b111111) begin
          if (per_en) begin
            checks++;
            if (cyc != SD) begin
              failures++;
              $display("FAIL slot_period an=%b actual=%0d expected=%0d", p_an, cyc, SD);
            end
          end
          if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if ({p_an, p_seg, p_dp} !== e) begin
              failures++;
              $display("FAIL slot an/seg/dp actual=%b/%b/%b expected=%b/%b/%b",
                       p_an, p_seg, p_dp, e.an, e.seg, e.dp);
            end
          end
        end
        if (an == 6'b011111) frame_cnt++;
        cyc = 0;
      end
      p_an = an; p_seg = seg; p_dp = dp;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0;
    int nb;
    exp_t e;
    #12;
    chk("reset_an", an, 6'b111111);
    chk("reset_seg", seg, 7'b1111111);
    chk("reset_dp", dp, 1);

    // 23:59:58 with hand-computed patterns; first frame right after release
    f0 = frame_cnt;
    @(negedge clk); rst = 1'b0; per_en = 1'b1;
    wait_frame_since(f0);
    e = '{6'b011111, 7'b0100100, 1'b1}; q.push_back(e);
    e = '{6'b101111, 7'b0110000, 1'b0}; q.push_back(e);
    e = '{6'b110111, 7'b0010010, 1'b1}; q.push_back(e);
    e = '{6'b111011, 7'b0010000, 1'b0}; q.push_back(e);
    e = '{6'b111101, 7'b0010010, 1'b1}; q.push_back(e);
    e = '{6'b111110, 7'b0000000, 1'b1}; q.push_back(e);
    drain();

    // snapshot: change 12:34:56 -> 12:35:00 during slot 2
    @(negedge clk); hour = 5'd12; minute = 6'd34; second = 6'd56;
    wait_frame_since(frame_cnt);
    push_frame(12, 34, 56);
    for (int i = 0; i < 4 * SD && an != 6'b110111; i++) @(posedge clk);
    chk("reach_slot2", an, 6'b110111);
    @(negedge clk); minute = 6'd35; second = 6'd0;
    push_frame(12, 35, 0);
    drain();

    // out-of-range and boundary values shown literally
    @(negedge clk); hour = 5'd31; minute = 6'd63; second = 6'd0;
    wait_frame_since(frame_cnt);
    push_frame(31, 63, 0);
    drain();
    @(negedge clk); hour = 5'd9; minute = 6'd10; second = 6'd19;
    wait_frame_since(frame_cnt);
    push_frame(9, 10, 19);
    drain();

    // reset mid-conversion, new value must appear in the first frame
    wait_frame_since(frame_cnt);
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midrst_an", an, 6'b111111);
    chk("midrst_seg", seg, 7'b1111111);
    chk("midrst_dp", dp, 1);
    hour = 5'd7; minute = 6'd8; second = 6'd9;
    repeat (2) @(negedge clk);
    f0 = frame_cnt;
    rst = 1'b0;
    wait_frame_since(f0);
    push_frame(7, 8, 9);
    drain();

`ifdef TIME_DISPLAY_BLINK_EN
    per_en = 1'b0;
    @(negedge clk); stop = 1'b1;
    for (int i = 0; i < 300 && an != 6'b111111; i++) @(negedge clk);
    nb = 0;
    for (int i = 0; i < 200 && an == 6'b111111; i++) begin nb++; @(negedge clk); end
    chk("blink_off_len", nb, 64);
    nb = 0;
    for (int i = 0; i < 200 && an != 6'b111111; i++) begin nb++; @(negedge clk); end
    chk("blink_on_len", nb, 64);
    stop = 1'b0;
    repeat (3) @(negedge clk);
    count_blank(200, nb);
    chk("stop0_no_blank", nb, 0);
`else
    @(negedge clk); stop = 1'b1;
    count_blank(200, nb);
    chk("stop_ignored", nb, 0);
    wait_frame_since(frame_cnt);
    push_frame(7, 8, 9);
    drain();
    stop = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/time_display.md
# time_display

Scanned six-digit seven-segment driver for the electronic clock. Consumes the binary `hour`/`minute`/`second` buses produced by the timekeeping counter, converts each field to two BCD digits with a sequential subtract-by-ten engine, and time-multiplexes the six digits onto a common-anode display. Sits between the time counter and the board display pins.

## Interface
- `SCAN_DIV`, default 50000: clk cycles per digit slot; legal range ≥ 32.
- `BLINK_DIV`, default 12500000: clk cycles per blink half-period; used only with `BLINK_EN`.
- `clk` in 1: system clock; all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `hour` in 5: binary hours, nominally 0–23.
- `minute` in 6: binary minutes, nominally 0–59.
- `second` in 6: binary seconds, nominally 0–59.
- `stop` in 1: clock is in adjust mode; drives blanking when `BLINK_EN` is defined.
- `an` out 6: digit enables, active-low one-hot; bit 5 is the leftmost digit.
- `seg` out 7: segments {g,f,e,d,c,b,a}, active-low.
- `dp` out 1: decimal point, active-low.

## Operation
- Digit order, slot 0..5: hour tens, hour ones, minute tens, minute ones, second tens, second ones. Slot k drives `an[5-k]` low.
- Scan divider: `div` counts 0..SCAN_DIV-1. At terminal count, `div` returns to 0 and slot index advances, wrapping 5→0.
- Frame start is the slot wrap 5→0, plus one forced start on the first cycle after reset release.
- Conversion FSM states:
  - IDLE: at frame start, go to LOAD.
  - LOAD: snapshot `hour`, `minute`, `second` into working registers, clear the tens accumulators, go to CONV_H.
  - CONV_H, CONV_M, CONV_S: each cycle, if the working value ≥ 10, subtract 10 and increment tens. Otherwise store the working value as ones and advance to the next state.
  - After CONV_S, go to COMMIT. COMMIT copies all six digits into the display BCD registers in one cycle, then returns to IDLE.
- Worst-case conversion is 1 + 4 + 7 + 7 + 1 = 20 cycles. It always completes within slot 0, so the display never shows a mixed frame.
- Out-of-range inputs are shown literally with no clamping: minute 63 shows "63", hour 31 shows "31". Digit values are always 0–9.
- Segment decode, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- `dp` is low during slots 1 and 3, giving the hh.mm.ss separators. It is high in all other slots.

## Timing
- `an`, `seg` and `dp` are registered. They change on the cycle after the slot index changes.
- Input changes are sampled only in LOAD. Any change mid-frame is displayed from the next COMMIT onward.
- Input-to-display latency: at most 6×SCAN_DIV + 22 cycles.
- Reset values: `an`=111111, `seg`=1111111, `dp`=1, `div`=0, slot=0, FSM=IDLE, all BCD registers=0, blink phase=on.
- Reset asserted mid-conversion aborts the conversion and clears working and display registers. A fresh conversion starts on the first cycle after release.
- The first valid display appears on slot 0 after the forced conversion completes, within SCAN_DIV+1 cycles of reset release.

## Configuration
- `TIME_DISPLAY_BLINK_EN` defined:
  - A BLINK_DIV counter toggles the blink phase.
  - While `stop`=1 and phase=off, `an` is forced to 111111 and scanning continues underneath.
  - When `stop` falls, the phase is reset to on and the counter to 0.
- Not defined: no blink logic, `stop` is ignored, and the display is always lit.

## Test plan
- Reset: assert `rst` asynchronously mid-slot. `an`=111111, `seg`=1111111 and `dp`=1 immediately, before the next clk edge.
- SCAN_DIV=32, inputs 23:59:58: over one frame, slots 0..5 show `seg` = 0100100, 0110000, 0010010, 0010000, 0010010, 0000000. `an` walks 011111→111110. `dp` is low only in slots 1 and 3.
- Scan period: each `an` value holds exactly 32 cycles, and the slot wraps 5→0 continuously.
- Snapshot: change 12:34:56→12:35:00 during slot 2. The current frame still shows "123456"; the next frame shows "123500".
- Out of range: minute=63, hour=31. Slot 2 shows 6 (0000010), slot 3 shows 3 (0110000), slot 0 shows 3, slot 1 shows 1.
- `TIME_DISPLAY_BLINK_EN`, BLINK_DIV=64, `stop`=1: `an` is 111111 for alternating 64-cycle windows. With `stop`=0 there is no blanking. Without the macro, `stop`=1 has no effect.
